synchronizer_filt: RTL and testbench
====================================

Name: synchronizer_filt

Overview:
- Multi-channel successor to the single-bit synchronizer. WIDTH independent async inputs pass through an SYNC_STAGES-deep flop chain each, followed by a per-channel glitch/debounce filter.
- Outputs are filtered levels plus single-cycle rise/fall event pulses.
- Placed at chip-level async inputs: GPIO, PPS, lock/status pins, button/jumper straps. Replaces ad-hoc synchronizer + edge-detect pairs.

Parameters:
- WIDTH, 1, number of independent channels.
- SYNC_STAGES, 2, synchronizer flops per channel; legal range 2..8.
- FILTER_CNT, 1, consecutive cycles a new synced value must persist before the output changes; legal range 1..65535. A value of 1 means no filtering: one extra register stage.
- INIT, {WIDTH{1'b0}}, WIDTH-bit reset value of every sync flop and filtered output, per channel.

Ports:
- clk  input  1  single clock; all logic is in this domain.
- rst_n  input  1  asynchronous active-low reset.
- a_in  input  WIDTH  async inputs; no timing relation to clk.
- s_out  output  WIDTH  filtered synchronous levels.
- s_rise  output  WIDTH  one-cycle pulse, per channel, on the 0->1 transition of s_out.
- s_fall  output  WIDTH  one-cycle pulse, per channel, on the 1->0 transition of s_out.
- s_chg  output  1  OR-reduction of (s_rise | s_fall).

Behaviour:
- Reset is asynchronous on assertion (rst_n low, without waiting for clk). It sets:
  - sreg[ch][*] = INIT[ch]
  - s_out = INIT
  - cnt = 0
  - s_rise = s_fall = s_chg = 0
- Deassertion is used as-is. The integrator supplies an already-synchronised release.
- Sync chain per channel:
  - Shift register of SYNC_STAGES flops, carrying the ASYNC_REG attribute.
  - s = last stage.
  - No logic between stages.
- Filter per channel:
  - State: q (= s_out[ch]) and counter cnt of width clog2(FILTER_CNT), minimum 1 bit.
  - Every clk edge:
    - if s == q: cnt <= 0
    - else if cnt == FILTER_CNT-1: q <= s, cnt <= 0
    - else: cnt <= cnt+1
  - Any cycle where s returns to q aborts the pending change and restarts the count from 0. Pulses shorter than FILTER_CNT cycles at s never reach s_out.
- Latency:
  - A clean step on a_in, meeting setup at edge N, appears on s_out after edge N+SYNC_STAGES+FILTER_CNT-1.
  - Example: SYNC_STAGES=2, FILTER_CNT=1 gives a new s_out value after the 2nd edge following capture.
  - Worst case adds one cycle for capture uncertainty.
- Edge pulses:
  - Registered, and asserted in the same cycle s_out takes its new value.
  - s_rise[ch] = 1 for exactly one cycle when q goes 0->1; s_fall[ch] likewise for 1->0.
  - Never both high on one channel in the same cycle.
- s_chg is registered as the OR of the next-state pulse vectors, so it is cycle-aligned with s_rise/s_fall.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
- No pulse is generated by reset assertion or release, even if a_in differs from INIT. The first transition after reset follows the normal filter path.
- Counter never wraps: it is cleared on match or on reaching FILTER_CNT-1.
- Reset mid-count discards the pending change.
- Illegal parameters (SYNC_STAGES<2, FILTER_CNT<1) stop elaboration via a generate-time error.

Optional Feature:
- Macro: SYNCHRONIZER_FILT_EDGE_EN.
- Defined: s_rise, s_fall and s_chg are generated as described above.
- Undefined:
  - Edge registers are not built.
  - s_rise, s_fall and s_chg are tied to 0.
  - s_out behaviour and latency are unchanged.

Test Plan:
- Reset: WIDTH=4, INIT=4'b1010, hold rst_n=0 with a_in=4'b0101, then toggle clk 10 cycles -> s_out=4'b1010 throughout reset, pulses all 0. On release, s_out reaches 0101 after 2+3 edges (SYNC_STAGES=2, FILTER_CNT=3), with s_rise=0101 and s_fall=1010 for one cycle, s_chg=1.
- Latency step: FILTER_CNT=3, a_in[0] 0->1 aligned to edge 0 -> s_out[0]=1 after edge 4. s_rise[0]=1 only in that cycle, s_fall=0.
- Glitch reject: FILTER_CNT=3, a_in[1] high for 2 cycles then low -> s_out[1] stays 0, no pulses. High for 3 cycles -> s_out[1] rises, then falls 3 cycles after the synced falling edge.
- Simultaneous channels: a_in 4'b0000->4'b1111 in one cycle -> all s_out bits change in the same cycle, s_rise=4'b1111 for one cycle, s_chg=1 for one cycle.
- Async reset mid-count: start a change on ch2, assert rst_n between clk edges at count 1 -> immediate s_out=INIT, cnt=0. No pulse after release until a fresh full-length change.
- Macro off: rebuild without SYNCHRONIZER_FILT_EDGE_EN and rerun the step test -> s_out timing identical, s_rise/s_fall/s_chg constantly 0.

Source files
------------

// File: rtl/synchronizer_filt.sv
// Multi-channel async-input synchronizer with a per-channel persistence filter
// and optional registered rise/fall/change pulses (enabled by SYNCHRONIZER_FILT_EDGE_EN).
module synchronizer_filt #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      FILTER_CNT  = 1,
  parameter logic [WIDTH-1:0] INIT        = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] s_rise,
  output logic [WIDTH-1:0] s_fall,
  output logic             s_chg
);

  localparam int unsigned CW = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CNT - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_sync_stages
    $error("synchronizer_filt: SYNC_STAGES must be in 2..8");
  end
  if (FILTER_CNT < 1 || FILTER_CNT > 65535) begin : g_bad_filter_cnt
    $error("synchronizer_filt: FILTER_CNT must be in 1..65535");
  end

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sreg [SYNC_STAGES];

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sreg[i] <= INIT;
    end else begin
      sreg[0] <= a_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sreg[i] <= sreg[i-1];
    end
  end

  assign s = sreg[SYNC_STAGES-1];

  // Any cycle where s matches the held level restarts the persistence count.
  always_comb begin
    q_next = s_out;
    for (int unsigned ch = 0; ch < WIDTH; ch++) begin
      cnt_next[ch] = cnt[ch];
      if (s[ch] == s_out[ch]) begin
        cnt_next[ch] = '0;
      end else if (cnt[ch] == CNT_MAX) begin
        q_next[ch]   = s[ch];
        cnt_next[ch] = '0;
      end else begin
        cnt_next[ch] = cnt[ch] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_out <= INIT;
      for (int unsigned ch = 0; ch < WIDTH; ch++) cnt[ch] <= '0;
    end else begin
      s_out <= q_next;
      for (int unsigned ch = 0; ch < WIDTH; ch++) cnt[ch] <= cnt_next[ch];
    end
  end

`ifdef SYNCHRONIZER_FILT_EDGE_EN
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  always_comb begin
    rise_next = q_next & ~s_out;
    fall_next = ~q_next & s_out;
  end

  // Pulses are derived from q_next so they land in the same cycle s_out changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rise <= '0;
      s_fall <= '0;
      s_chg  <= 1'b0;
    end else begin
      s_rise <= rise_next;
      s_fall <= fall_next;
      s_chg  <= |(rise_next | fall_next);
    end
  end
`else
  assign s_rise = '0;
  assign s_fall = '0;
  assign s_chg  = 1'b0;
`endif

endmodule

// File: tb/tb_synchronizer_filt.sv
// Directed scoreboard bench for synchronizer_filt (WIDTH=4, SYNC_STAGES=2, FILTER_CNT=3, INIT=1010).
module tb_synchronizer_filt;

`ifdef SYNCHRONIZER_FILT_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] a_in = 4'b0101;
  logic [3:0] s_out, s_rise, s_fall;
  logic       s_chg;

  typedef struct {
    logic [3:0] so;
    logic [3:0] r;
    logic [3:0] f;
    logic       c;
  } exp_t;

  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  string tag = "init";

  synchronizer_filt #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .FILTER_CNT(3),
    .INIT(4'b1010)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a_in(a_in),
    .s_out(s_out),
    .s_rise(s_rise),
    .s_fall(s_fall),
    .s_chg(s_chg)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input logic [3:0] so, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.so = so;
    e.r  = EDGE ? r : 4'b0000;
    e.f  = EDGE ? f : 4'b0000;
    e.c  = EDGE & (|(r | f));
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb: got empty queue expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (s_out === e.so) else begin
        errors++;
        $error("FAIL %s_s_out: got %b expected %b", tag, s_out, e.so);
      end
      checks++;
      assert (s_rise === e.r) else begin
        errors++;
        $error("FAIL %s_s_rise: got %b expected %b", tag, s_rise, e.r);
      end
      checks++;
      assert (s_fall === e.f) else begin
        errors++;
        $error("FAIL %s_s_fall: got %b expected %b", tag, s_fall, e.f);
      end
      checks++;
      assert (s_chg === e.c) else begin
        errors++;
        $error("FAIL %s_s_chg: got %b expected %b", tag, s_chg, e.c);
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_pop();
    end
  endtask

  // New a_in captured at the next edge; s_out follows on the 5th edge (2 sync + 3 filter).
  task automatic apply(input logic [3:0] nv, input logic [3:0] cur);
    a_in = nv;
    repeat (4) push_exp(cur, 4'b0000, 4'b0000);
    push_exp(nv, nv & ~cur, cur & ~nv);
    push_exp(nv, 4'b0000, 4'b0000);
    run_cycles(6);
  endtask

  initial begin
    // Reset asserted between edges: takes effect without a clock.
    tag = "reset_async";
    #2 rst_n = 1'b0;
    #1;
    push_exp(4'b1010, 4'b0000, 4'b0000);
    check_pop();

    tag = "reset_hold";
    repeat (10) push_exp(4'b1010, 4'b0000, 4'b0000);
    run_cycles(10);

    tag = "reset_release";
    rst_n = 1'b1;
    apply(4'b0101, 4'b1010);

    tag = "settle";
    apply(4'b0000, 4'b0101);

    tag = "latency_step";
    apply(4'b0001, 4'b0000);
    tag = "latency_back";
    apply(4'b0000, 4'b0001);

    // Two-cycle pulse on ch1 never persists for three synced cycles.
    tag = "glitch_reject";
    repeat (8) push_exp(4'b0000, 4'b0000, 4'b0000);
    a_in = 4'b0010;
    run_cycles(2);
    a_in = 4'b0000;
    run_cycles(6);

    tag = "glitch_pass";
    repeat (4) push_exp(4'b0000, 4'b0000, 4'b0000);
    push_exp(4'b0010, 4'b0010, 4'b0000);
    repeat (2) push_exp(4'b0010, 4'b0000, 4'b0000);
    push_exp(4'b0000, 4'b0000, 4'b0010);
    push_exp(4'b0000, 4'b0000, 4'b0000);
    a_in = 4'b0010;
    run_cycles(3);
    a_in = 4'b0000;
    run_cycles(6);

    tag = "simultaneous";
    apply(4'b1111, 4'b0000);

    // Start a ch2 change, then reset while its count is 1.
    tag = "midcount_pre";
    a_in = 4'b1011;
    repeat (3) push_exp(4'b1111, 4'b0000, 4'b0000);
    run_cycles(3);
    #3 rst_n = 1'b0;
    #1;
    tag = "midcount_reset";
    push_exp(4'b1010, 4'b0000, 4'b0000);
    check_pop();
    repeat (3) push_exp(4'b1010, 4'b0000, 4'b0000);
    run_cycles(3);

    tag = "midcount_release";
    rst_n = 1'b1;
    apply(4'b1011, 4'b1010);

    tag = "drain";
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s: got %0d leftover expected 0", tag, sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
